// File: rtl/csa_accum.sv
// Carry-save multi-operand accumulator: one operand per cycle into redundant (S, C) form,
// then a segmented ripple resolve of S + C, one SEG_W slice per cycle, LSB first.
module csa_accum #(
   parameter int unsigned BW     = 8,
   parameter int unsigned ACC_W  = 16,
   parameter int unsigned SEG_W  = 4,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BW-1:0]    in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_cnt_ovf
);

   localparam int unsigned NSEG    = ACC_W / SEG_W;
   localparam int unsigned SegIdxW = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [SegIdxW-1:0] LastSeg = SegIdxW'(NSEG - 1);

   typedef enum logic [1:0] {StAcc, StResolve, StDone} state_e;

   state_e             r_state;
   logic [ACC_W-1:0]   r_s;
   logic [ACC_W-1:0]   r_c;
   logic [ACC_W-1:0]   r_result;
   logic [CNT_W-1:0]   r_count;
   logic               r_ovf;
   logic [SegIdxW-1:0] r_seg;
   logic               r_cin;
   logic               r_in_ready;
   logic               r_out_valid;

   logic [ACC_W-1:0]   w_x;
   logic [ACC_W-1:0]   w_maj;
   logic [31:0]        w_base;
   logic [SEG_W:0]     w_seg_sum;
   logic               w_accept;

   always_comb begin
      if (SIGNED != 0) begin
         w_x = {{(ACC_W-BW){in_data[BW-1]}}, in_data};
      end else begin
         w_x = {{(ACC_W-BW){1'b0}}, in_data};
      end
      w_maj     = (r_s & r_c) | (r_s & w_x) | (r_c & w_x);
      w_base    = 32'(r_seg) * SEG_W;
      w_seg_sum = {1'b0, r_s[w_base +: SEG_W]} + {1'b0, r_c[w_base +: SEG_W]}
                + {{SEG_W{1'b0}}, r_cin};
      // in_ready is only ever high in StAcc, so it alone qualifies the accept
      w_accept  = in_valid & r_in_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StAcc;
         r_s         <= '0;
         r_c         <= '0;
         r_result    <= '0;
         r_count     <= '0;
         r_ovf       <= 1'b0;
         r_seg       <= '0;
         r_cin       <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         unique case (r_state)
            StAcc: begin
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  r_s <= r_s ^ r_c ^ w_x;
                  r_c <= {w_maj[ACC_W-2:0], 1'b0};
                  if (r_count == '1) begin
                     r_ovf <= 1'b1;
                  end else begin
                     r_count <= r_count + 1'b1;
                  end
                  if (in_last) begin
                     r_state    <= StResolve;
                     r_seg      <= '0;
                     r_cin      <= 1'b0;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            StResolve: begin
               r_result[w_base +: SEG_W] <= w_seg_sum[SEG_W-1:0];
               r_cin                     <= w_seg_sum[SEG_W];
               if (r_seg == LastSeg) begin
                  r_state     <= StDone;
                  r_out_valid <= 1'b1;
               end else begin
                  r_seg <= r_seg + 1'b1;
               end
            end
            StDone: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_s         <= '0;
                  r_c         <= '0;
                  r_count     <= '0;
                  r_ovf       <= 1'b0;
                  r_state     <= StAcc;
                  r_in_ready  <= 1'b1;
               end
            end
            default: r_state <= StAcc;
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_sum     = r_result;
   assign out_count   = r_count;
   assign out_cnt_ovf = r_ovf;

endmodule

// File: tb/tb_csa_accum.sv
// Directed bench for csa_accum: default, signed, and narrow-count/short-accumulator builds.
module tb_csa_accum;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       v0, v1, v2;
   logic [7:0] din;
   logic       last;
   logic       ordy;

   logic        rdy0, rdy1, rdy2;
   logic        ov0, ov1, ov2;
   logic [15:0] sum0, sum1;
   logic [8:0]  sum2;
   logic [7:0]  cnt0, cnt1;
   logic [1:0]  cnt2;
   logic        ovf0, ovf1, ovf2;

   int n_err = 0;
   int n_chk = 0;

   csa_accum u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_data(din),
      .in_last(last), .out_valid(ov0), .out_ready(ordy), .out_sum(sum0),
      .out_count(cnt0), .out_cnt_ovf(ovf0)
   );

   csa_accum #(.SIGNED(1)) u_sgn (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(din),
      .in_last(last), .out_valid(ov1), .out_ready(ordy), .out_sum(sum1),
      .out_count(cnt1), .out_cnt_ovf(ovf1)
   );

   csa_accum #(.BW(8), .ACC_W(9), .SEG_W(3), .CNT_W(2), .SIGNED(0)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_data(din),
      .in_last(last), .out_valid(ov2), .out_ready(ordy), .out_sum(sum2),
      .out_count(cnt2), .out_cnt_ovf(ovf2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // which: 0/1/2 selects one DUT, 3 drives u_dut and u_sgn together
   task automatic send(input int which, input logic [7:0] d, input logic l);
      logic r;
      bit   done;
      done = 1'b0;
      din  = d;
      last = l;
      v0   = (which == 0 || which == 3);
      v1   = (which == 1);
      v2   = (which == 2);
      if (which == 3) v1 = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         r = (which == 1) ? rdy1 : (which == 2) ? rdy2 : rdy0;
         if (r) done = 1'b1;
         tick();
      end
      v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; last = 1'b0;
      if (!done) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_valid(input int which, input int exp_lat, input string tag);
      int   lat;
      logic v;
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         tick();
         v = (which == 1) ? ov1 : (which == 2) ? ov2 : ov0;
         if (v) lat = i;
      end
      chk(tag, lat, exp_lat);
   endtask

   task automatic release_out();
      ordy = 1'b1;
      tick();
      ordy = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; ordy = 1'b0; v0 = 1'b1; v1 = 1'b0; v2 = 1'b0;
      din = 8'hAA; last = 1'b0;

      // 1: reset holds everything quiet even with in_valid high
      repeat (3) tick();
      chk("rst_in_ready", rdy0, 0);
      chk("rst_out_valid", ov0, 0);
      chk("rst_out_sum", sum0, 0);
      chk("rst_out_count", cnt0, 0);
      v0 = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", rdy0, 1);

      // 2: 3 + 5 + 7
      send(0, 8'd3, 1'b0);
      send(0, 8'd5, 1'b0);
      send(0, 8'd7, 1'b1);
      chk("t2_no_early_valid", ov0, 0);
      wait_valid(0, 4, "t2_latency");
      chk("t2_sum", sum0, 16'h000F);
      chk("t2_count", cnt0, 3);
      chk("t2_ovf", ovf0, 0);
      chk("t2_in_ready_done", rdy0, 0);
      release_out();
      chk("t2_valid_drop", ov0, 0);
      chk("t2_in_ready_back", rdy0, 1);
      chk("t2_count_clear", cnt0, 0);

      // 3: FF, FF, 02 unsigned vs signed
      send(3, 8'hFF, 1'b0);
      send(3, 8'hFF, 1'b0);
      send(3, 8'h02, 1'b1);
      wait_valid(0, 4, "t3_latency");
      chk("t3_unsigned_sum", sum0, 16'h0200);
      chk("t3_signed_valid", ov1, 1);
      chk("t3_signed_sum", sum1, 16'h0000);
      chk("t3_signed_count", cnt1, 3);
      release_out();

      // 4: backpressure in DONE, in_valid must be ignored
      send(0, 8'h10, 1'b0);
      send(0, 8'h20, 1'b1);
      wait_valid(0, 4, "t4_latency");
      v0 = 1'b1; din = 8'h55; last = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_hold_valid", ov0, 1);
         chk("t4_hold_sum", sum0, 16'h0030);
         chk("t4_hold_in_ready", rdy0, 0);
      end
      v0 = 1'b0; last = 1'b0;
      release_out();
      chk("t4_ignored_count", cnt0, 0);
      send(0, 8'h01, 1'b1);
      wait_valid(0, 4, "t4b_latency");
      chk("t4b_sum", sum0, 16'h0001);
      chk("t4b_count", cnt0, 1);
      release_out();

      // 5: 5 x FF into 9-bit accumulator with 2-bit count: 1275 mod 512 = 251
      for (int i = 0; i < 4; i++) send(2, 8'hFF, 1'b0);
      send(2, 8'hFF, 1'b1);
      wait_valid(2, 3, "t5_latency");
      chk("t5_sum", sum2, 9'h0FB);
      chk("t5_count_sat", cnt2, 3);
      chk("t5_ovf", ovf2, 1);
      release_out();
      chk("t5_ovf_clear", ovf2, 0);
      chk("t5_count_clear", cnt2, 0);

      // 6: reset during resolve segment 2 aborts the frame
      send(0, 8'd4, 1'b0);
      send(0, 8'd4, 1'b1);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      tick();
      chk("t6_rst_valid", ov0, 0);
      chk("t6_rst_in_ready", rdy0, 0);
      chk("t6_rst_sum", sum0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t6_no_valid", ov0, 0);
      end
      chk("t6_in_ready", rdy0, 1);
      send(0, 8'd1, 1'b0);
      send(0, 8'd1, 1'b1);
      wait_valid(0, 4, "t6_latency");
      chk("t6_sum", sum0, 16'h0002);
      chk("t6_count", cnt0, 2);
      chk("t6_ovf", ovf0, 0);
      release_out();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
